song_sequencer: RTL and testbench

//  Upstream feeder for the note player stage. Walks one song in an external synchronous

---
 rtl/song_sequencer.sv | 161 ++++++++++++++++
 tb/tb_song_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// Song ROM walker feeding the note player: fetch {note, duration}, pulse new_note, wait for done.
// Optional SONG_LOOP_EN: end of song restarts at entry 0 instead of stopping in DONE.
module song_sequencer #(
   parameter int unsigned NOTE_W = 6,
   parameter int unsigned DUR_W  = 6,
   parameter int unsigned SONG_W = 2,
   parameter int unsigned IDX_W  = 5
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     play,
   input  logic [SONG_W-1:0]        song_sel,
   input  logic                     new_song,
   input  logic                     note_done,
   output logic [SONG_W+IDX_W-1:0]  rom_addr,
   input  logic [NOTE_W+DUR_W-1:0]  rom_data,
   output logic [NOTE_W-1:0]        note_out,
   output logic [DUR_W-1:0]         duration_out,
   output logic                     new_note,
   output logic                     song_done
);

   typedef enum logic [2:0] {
      StIdle, StFetch, StWaitRom, StLoad, StPlaying, StAdvance, StDone
   } state_e;

   localparam logic [IDX_W-1:0] LastIdx = '1;
   localparam logic [IDX_W-1:0] IdxOne  = {{(IDX_W-1){1'b0}}, 1'b1};

   state_e              state_q, state_d;
   logic [SONG_W-1:0]   song_q, song_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [NOTE_W-1:0]   note_q, note_d;
   logic [DUR_W-1:0]    dur_q, dur_d;
   logic                blank_q, blank_d;
   logic                song_done_q, song_done_d;

   logic [NOTE_W-1:0]   rom_note;
   logic [DUR_W-1:0]    rom_dur;
   logic                active;
   logic                end_marker;
   logic                last_entry;
   logic                end_evt;

   assign rom_note   = rom_data[NOTE_W+DUR_W-1:DUR_W];
   assign rom_dur    = rom_data[DUR_W-1:0];
   // new_song takes priority over everything; play=0 freezes all other progress
   assign active     = play && !new_song;
   assign end_marker = (state_q == StWaitRom) && (rom_dur == '0);
   assign last_entry = (state_q == StAdvance) && (idx_q == LastIdx);
   assign end_evt    = active && (end_marker || last_entry);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (new_song) begin
         state_d = StFetch;
      end else if (play) begin
         unique case (state_q)
            StIdle:    state_d = StIdle;
            StFetch:   state_d = StWaitRom;
`ifdef SONG_LOOP_EN
            StWaitRom: state_d = end_marker ? StFetch : StLoad;
`else
            StWaitRom: state_d = end_marker ? StDone : StLoad;
`endif
            StLoad:    state_d = StPlaying;
            // Player done is still high from the previous note during the blank cycle
            StPlaying: state_d = (!blank_q && note_done) ? StAdvance : StPlaying;
`ifdef SONG_LOOP_EN
            StAdvance: state_d = StFetch;
`else
            StAdvance: state_d = last_entry ? StDone : StFetch;
`endif
            StDone:    state_d = StDone;
            default:   state_d = StIdle;
         endcase
      end
   end

   // Output logic
   always_comb begin
      new_note = 1'b0;
      if (state_q == StLoad) begin
         new_note = active;
      end
   end

   // Datapath next-state
   always_comb begin
      song_d  = song_q;
      idx_d   = idx_q;
      note_d  = note_q;
      dur_d   = dur_q;
      blank_d = blank_q;
      if (new_song) begin
         song_d  = song_sel;
         idx_d   = '0;
         blank_d = 1'b0;
      end else if (active) begin
         if (state_q == StWaitRom) begin
            note_d = rom_note;
            dur_d  = rom_dur;
         end
         if (state_q == StLoad) begin
            blank_d = 1'b1;
         end
         if (state_q == StPlaying) begin
            blank_d = 1'b0;
         end
         if ((state_q == StAdvance) && !last_entry) begin
            idx_d = idx_q + IdxOne;
         end
`ifdef SONG_LOOP_EN
         if (end_evt) begin
            idx_d = '0;
         end
`endif
      end
   end

`ifdef SONG_LOOP_EN
   // One-cycle pulse per loop; new_song suppresses end_evt so it also clears the flag
   assign song_done_d = end_evt;
`else
   assign song_done_d = new_song ? 1'b0 : (song_done_q || end_evt);
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         song_q      <= '0;
         idx_q       <= '0;
         note_q      <= '0;
         dur_q       <= '0;
         blank_q     <= 1'b0;
         song_done_q <= 1'b0;
      end else begin
         song_q      <= song_d;
         idx_q       <= idx_d;
         note_q      <= note_d;
         dur_q       <= dur_d;
         blank_q     <= blank_d;
         song_done_q <= song_done_d;
      end
   end

   assign rom_addr     = {song_q, idx_q};
   assign note_out     = note_q;
   assign duration_out = dur_q;
   assign song_done    = song_done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer (default build): ROM model, pulse counter, immediate asserts.
module tb_song_sequencer;

   logic        clk;
   logic        reset_n;
   logic        play;
   logic [1:0]  song_sel;
   logic        new_song;
   logic        note_done;
   logic [6:0]  rom_addr;
   logic [11:0] rom_data;
   logic [5:0]  note_out;
   logic [5:0]  duration_out;
   logic        new_note;
   logic        song_done;

   logic [11:0] rom [128];
   int          total = 0;
   int          bad = 0;
   int          pulses = 0;
   int          p0;

   song_sequencer dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .play         (play),
      .song_sel     (song_sel),
      .new_song     (new_song),
      .note_done    (note_done),
      .rom_addr     (rom_addr),
      .rom_data     (rom_data),
      .note_out     (note_out),
      .duration_out (duration_out),
      .new_note     (new_note),
      .song_done    (song_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom[rom_addr];

   // Count load pulses mid-cycle, away from the active edge
   always @(negedge clk) if (reset_n && new_note) pulses <= pulses + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) rom[i] = 12'h000;
      rom[0]  = {6'd5, 6'd2};
      rom[1]  = {6'd0, 6'd0};
      for (int i = 0; i < 32; i++) rom[32+i] = {6'(i + 1), 6'd1};
      rom[64] = {6'd10, 6'd3};
      rom[65] = {6'd11, 6'd4};
      rom[66] = {6'd0, 6'd0};
      rom[96] = {6'd20, 6'd7};
      rom[97] = {6'd21, 6'd8};
      rom[98] = {6'd0, 6'd0};

      reset_n = 1'b0; play = 1'b0; song_sel = 2'd0; new_song = 1'b0; note_done = 1'b0;
      tick();
      tick();
      chk("rst_addr", 32'(rom_addr), 32'h0);
      chk("rst_note", 32'(note_out), 32'h0);
      chk("rst_dur", 32'(duration_out), 32'h0);
      chk("rst_new_note", 32'(new_note), 32'h0);
      chk("rst_song_done", 32'(song_done), 32'h0);
      reset_n = 1'b1;
      tick();
      chk("idle_addr", 32'(rom_addr), 32'h0);

      // 1: start song 2, first note after three edges
      song_sel = 2'd2; new_song = 1'b1; play = 1'b1;
      tick();
      new_song = 1'b0;
      chk("t1_addr", 32'(rom_addr), 32'h40);
      chk("t1_nn_fetch", 32'(new_note), 32'h0);
      tick();
      chk("t1_nn_wait", 32'(new_note), 32'h0);
      tick();
      chk("t1_nn_load", 32'(new_note), 32'h1);
      chk("t1_note", 32'(note_out), 32'd10);
      chk("t1_dur", 32'(duration_out), 32'd3);

      // 2: stale note_done held through LOAD is blanked for one cycle
      note_done = 1'b1;
      tick();
      chk("t2_nn_blank", 32'(new_note), 32'h0);
      chk("t2_addr_blank", 32'(rom_addr), 32'h40);
      tick();
      chk("t2_addr_play", 32'(rom_addr), 32'h40);
      tick();
      chk("t2_addr_adv", 32'(rom_addr), 32'h40);
      tick();
      chk("t2_addr_idx1", 32'(rom_addr), 32'h41);
      note_done = 1'b0;
      tick();
      tick();
      chk("t2_nn_load", 32'(new_note), 32'h1);
      chk("t2_note", 32'(note_out), 32'd11);
      chk("t2_dur", 32'(duration_out), 32'd4);

      // 5: pause inside the blank cycle; everything incl. blank counter freezes
      tick();
      play = 1'b0; note_done = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t5_nn_pause", 32'(new_note), 32'h0);
         chk("t5_addr_pause", 32'(rom_addr), 32'h41);
         chk("t5_note_pause", 32'(note_out), 32'd11);
      end
      play = 1'b1;
      tick();
      chk("t5_addr_blank", 32'(rom_addr), 32'h41);
      tick();
      chk("t5_addr_adv", 32'(rom_addr), 32'h41);
      tick();
      chk("t5_addr_idx2", 32'(rom_addr), 32'h42);
      tick();
      chk("t5_done_wait", 32'(song_done), 32'h0);
      tick();
      chk("t5_song_done", 32'(song_done), 32'h1);
      chk("t5_marker_note", 32'(note_out), 32'd0);
      chk("t5_marker_dur", 32'(duration_out), 32'd0);
      chk("t5_nn_done", 32'(new_note), 32'h0);

      // 3: song 0, marker at entry 1; new_song clears song_done
      p0 = pulses;
      song_sel = 2'd0; new_song = 1'b1;
      tick();
      new_song = 1'b0;
      chk("t3_done_clr", 32'(song_done), 32'h0);
      chk("t3_addr", 32'(rom_addr), 32'h00);
      for (int i = 0; i < 50 && !song_done; i++) tick();
      chk("t3_song_done", 32'(song_done), 32'h1);
      chk("t3_pulses", 32'(pulses - p0), 32'd1);
      chk("t3_note", 32'(note_out), 32'd0);
      for (int i = 0; i < 5; i++) tick();
      chk("t3_no_more", 32'(pulses - p0), 32'd1);
      chk("t3_hold_done", 32'(song_done), 32'h1);

      // 4: 32 non-zero entries, stop at last index without wrap
      p0 = pulses;
      song_sel = 2'd1; new_song = 1'b1;
      tick();
      new_song = 1'b0;
      for (int i = 0; i < 400 && !song_done; i++) tick();
      chk("t4_song_done", 32'(song_done), 32'h1);
      chk("t4_pulses", 32'(pulses - p0), 32'd32);
      chk("t4_last_note", 32'(note_out), 32'd32);
      chk("t4_last_dur", 32'(duration_out), 32'd1);
      chk("t4_addr", 32'(rom_addr), 32'h3F);
      for (int i = 0; i < 6; i++) tick();
      chk("t4_no_more", 32'(pulses - p0), 32'd32);

      // 6a: new_song wins over a coincident note_done
      note_done = 1'b0; song_sel = 2'd3; new_song = 1'b1;
      tick();
      new_song = 1'b0;
      chk("t6_addr_s3", 32'(rom_addr), 32'h60);
      tick();
      tick();
      chk("t6_nn_load", 32'(new_note), 32'h1);
      chk("t6_note_s3", 32'(note_out), 32'd20);
      chk("t6_dur_s3", 32'(duration_out), 32'd7);
      tick();
      tick();
      song_sel = 2'd2; new_song = 1'b1; note_done = 1'b1;
      chk("t6_nn_coinc", 32'(new_note), 32'h0);
      tick();
      new_song = 1'b0; note_done = 1'b0;
      chk("t6_addr_restart", 32'(rom_addr), 32'h40);
      tick();
      tick();
      chk("t6_nn_restart", 32'(new_note), 32'h1);
      chk("t6_note_restart", 32'(note_out), 32'd10);

      // 6b: asynchronous reset in the middle of FETCH
      song_sel = 2'd3; new_song = 1'b1;
      tick();
      new_song = 1'b0;
      chk("t6_addr_fetch", 32'(rom_addr), 32'h60);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_rst_addr", 32'(rom_addr), 32'h0);
      chk("t6_rst_note", 32'(note_out), 32'h0);
      chk("t6_rst_dur", 32'(duration_out), 32'h0);
      chk("t6_rst_nn", 32'(new_note), 32'h0);
      chk("t6_rst_done", 32'(song_done), 32'h0);
      p0 = pulses;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      tick();
      tick();
      chk("t6_post_addr", 32'(rom_addr), 32'h0);
      chk("t6_post_pulses", 32'(pulses - p0), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
